// File: rtl/dbus_bridge_if.sv
// dbus_bridge_if: data-bus / cache-bus request and response types plus the bridge interface
package dbus_pkg;
  typedef enum logic [2:0] {MSIZE1 = 3'd0, MSIZE2 = 3'd1, MSIZE4 = 3'd2, MSIZE8 = 3'd3} msize_t;
  typedef logic [3:0] mlen_t;
  typedef logic [1:0] axi_burst_t;
  localparam mlen_t MLEN1 = 4'h0;
  localparam axi_burst_t AXI_BURST_FIXED = 2'b00;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    mlen_t       len;
    axi_burst_t  burst;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

interface dbus_bridge_if;
  dbus_pkg::dbus_req_t  dreq;
  dbus_pkg::dbus_resp_t dresp;
  dbus_pkg::cbus_req_t  creq;
  dbus_pkg::cbus_resp_t cresp;
  modport slave (input dreq, input cresp, output dresp, output creq);
  modport master (output dreq, output cresp, input dresp, input creq);
endinterface

// File: rtl/dbus_bridge.sv
// dbus_bridge: turns one data-bus access into a single-beat cache-bus request and returns a one-cycle response
module dbus_bridge
  import dbus_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  dbus_bridge_if.slave     bus,
  output logic             busy,
  output logic [CNT_W-1:0] wait_cycles
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t           r_state;
  logic             r_valid, r_wr, r_ok, r_busy;
  logic [63:0]      r_addr, r_wdata, r_rdata;
  msize_t           r_size;
  logic [7:0]       r_strobe;
  logic [CNT_W-1:0] r_cnt, r_wait;
  logic [CNT_W-1:0] w_cnt_nxt;
  assign w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  // Every output is a register, so an async reset clears the bus outputs in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_wr     <= 1'b0;
      r_ok     <= 1'b0;
      r_busy   <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_size   <= MSIZE1;
      r_strobe <= '0;
      r_cnt    <= '0;
      r_wait   <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.dreq.valid) begin
          r_addr   <= bus.dreq.addr;
          r_size   <= bus.dreq.size;
          r_strobe <= bus.dreq.strobe;
          r_wdata  <= bus.dreq.data;
          r_wr     <= |bus.dreq.strobe;
          r_cnt    <= '0;
          r_valid  <= 1'b1;
          r_busy   <= 1'b1;
          r_state  <= ACCESS;
        end
        ACCESS: begin
          r_cnt <= w_cnt_nxt;
          if (bus.cresp.ready && bus.cresp.last) begin
            r_rdata <= bus.cresp.data;
            r_wait  <= w_cnt_nxt;
            r_ok    <= 1'b1;
            r_valid <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_ok    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.creq = '{valid: r_valid, is_write: r_wr, size: r_size, addr: r_addr, strobe: r_strobe,
                      data: r_wdata, len: MLEN1, burst: AXI_BURST_FIXED};
  assign bus.dresp = '{addr_ok: r_ok, data_ok: r_ok, data: r_rdata};
  assign busy = r_busy;
  assign wait_cycles = r_wait;
endmodule

// File: tb/tb_dbus_bridge.sv
// tb_dbus_bridge: directed accesses with a response scoreboard checked by an independent monitor
module tb_dbus_bridge;
  import dbus_pkg::*;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       busy;
  logic [7:0] wc;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         n_push = 0;
  typedef struct {
    logic [63:0] d;
    logic [7:0]  w;
  } exp_t;
  exp_t sb[$];
  int   pulses[$];

  dbus_bridge_if bus();
  dbus_bridge #(.CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy), .wait_cycles(wc));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.dresp.data_ok || bus.dresp.addr_ok) begin
      exp_t e;
      pulses.push_back(cyc);
      chk("addr_ok", bus.dresp.addr_ok, 1);
      chk("data_ok", bus.dresp.data_ok, 1);
      if (sb.size() == 0) chk("unexpected_resp", 1, 0);
      else begin
        e = sb.pop_front();
        chk("resp_data", bus.dresp.data, e.d);
        chk("wait_cycles", wc, e.w);
      end
    end
  end

  // Drives one access; returns at the negedge of the DONE cycle.
  task automatic acc(input logic [63:0] a, input msize_t sz, input logic [7:0] s, input logic [63:0] wd,
                     input int d, input logic nl, input logic [63:0] rd);
    int n = 0;
    exp_t e;
    e.d = rd;
    e.w = (d + 1 > 255) ? 8'd255 : 8'(d + 1);
    sb.push_back(e);
    n_push++;
    bus.dreq = '{valid: 1'b1, addr: a, size: sz, strobe: s, data: wd};
    while (!bus.creq.valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("enter_access", bus.creq.valid, 1);
    bus.dreq = '{valid: 1'b0, addr: 64'h0, size: MSIZE1, strobe: ~s, data: ~wd};
    for (int i = 0; i <= d; i++) begin
      chk("creq_valid", bus.creq.valid, 1);
      chk("is_write", bus.creq.is_write, |s);
      chk("creq_addr", bus.creq.addr, a);
      chk("creq_strobe", bus.creq.strobe, s);
      chk("creq_data", bus.creq.data, wd);
      chk("creq_size", bus.creq.size, sz);
      chk("creq_len", bus.creq.len, MLEN1);
      chk("creq_burst", bus.creq.burst, AXI_BURST_FIXED);
      chk("busy_access", busy, 1);
      bus.cresp = '{ready: (i == d) || nl, last: (i == d), data: (i == d) ? rd : ~rd};
      @(negedge clk);
    end
    bus.cresp = '0;
    chk("creq_valid_done", bus.creq.valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, n;
    bus.dreq = '0;
    bus.cresp = '0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_creq_valid", bus.creq.valid, 0);
    chk("rst_ok", {bus.dresp.addr_ok, bus.dresp.data_ok}, 0);
    chk("rst_data", bus.dresp.data, 0);
    chk("rst_wait", wc, 0);
    chk("rst_addr", bus.creq.addr, 0);
    @(negedge clk);
    rst = 1'b1;
    acc(64'h8000_0010, MSIZE8, 8'h00, 64'h0, 0, 1'b0, 64'h1122_3344_5566_7788);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    acc(64'h8000_0010, MSIZE4, 8'h0F, 64'hDEAD_BEEF, 5, 1'b0, 64'h0000_0000_AAAA_5555);
    @(negedge clk);
    idx = pulses.size();
    acc(64'h8000_0100, MSIZE8, 8'h00, 64'h0, 0, 1'b0, 64'hCAFE_0000_0000_0001);
    acc(64'h8000_0108, MSIZE8, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 1'b0, 64'hCAFE_0000_0000_0002);
    @(negedge clk);
    chk("b2b_pulses", pulses.size(), idx + 2);
    if (pulses.size() == idx + 2) chk("b2b_gap", pulses[idx+1] - pulses[idx], 3);
    acc(64'h8000_0200, MSIZE2, 8'h03, 64'h0000_0000_0000_BEEF, 2, 1'b1, 64'h5A5A_5A5A_5A5A_5A5A);
    @(negedge clk);
    bus.dreq = '{valid: 1'b1, addr: 64'h8000_0300, size: MSIZE8, strobe: 8'h00, data: 64'h0};
    n = 0;
    while (!bus.creq.valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("abort_enter", bus.creq.valid, 1);
    bus.dreq = '0;
    rst = 1'b0;
    #1;
    chk("abort_creq_valid", bus.creq.valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_data_ok", bus.dresp.data_ok, 0);
    chk("abort_wait", wc, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    acc(64'h8000_0400, MSIZE8, 8'h00, 64'h0, 1, 1'b0, 64'h7777_8888_9999_0000);
    @(negedge clk);
    acc(64'h8000_0500, MSIZE8, 8'h00, 64'h0, 299, 1'b1, 64'h1234_5678_9ABC_DEF0);
    @(negedge clk);
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("pulse_count", pulses.size(), n_push);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
